mem_port_arbiter: RTL and testbench

- Shares one single-ported 16-bit data memory between NUM_REQ Core-style masters (instruction fetch, data port, DMA).
- Round-robin arbitration, one transaction at a time, fixed memory read latency.
- Sits between the Cores' Address/WriteData/WriteEnable/ReadData buses and the memory.
- Masters see a request/acknowledge handshake.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_port_arbiter_rr_pick.sv | 32 +++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
// Used by mem_port_arbiter and rr_pick.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arbState_t;

  // Read latency counter; READ_LAT is at most 15.
  localparam int CNT_W = 4;

  // Widest flattened request bus the slicer accepts (8 x 32 bits).
  localparam int BUS_MAX = 256;

  // Pull slice idx of width w out of a zero-padded flattened bus.
  function automatic logic [31:0] busSlice(
    input logic [BUS_MAX-1:0] bus,
    input int                 idx,
    input int                 w
  );
    busSlice = 32'(bus >> (idx * w));
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or
// after ptr, wrapping, reported as one-hot grant plus index.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  reqVec,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan N positions starting at ptr; first hit wins.
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && reqVec[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory.
// Optional MEM_ARB_LOCK_EN adds Lock for atomic RMW pairs.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int READ_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    Req,
  input  logic [NUM_REQ-1:0]    Wr,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]    Lock,
`endif
  input  logic [NUM_REQ*AW-1:0] ReqAddr,
  input  logic [NUM_REQ*DW-1:0] ReqWData,
  output logic [NUM_REQ-1:0]    Ack,
  output logic [DW-1:0]         RData,
  output logic [NUM_REQ-1:0]    Grant,
  output logic                  Busy,
  output logic [AW-1:0]         Address,
  output logic [DW-1:0]         WriteData,
  output logic                  WriteEnable,
  input  logic [DW-1:0]         ReadData
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  arbState_t          state;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      gIdx;
  logic [IW-1:0]      nextPtr;
  logic               gWr;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] pickGnt;
  logic [IW-1:0]      pickIdx;
  logic               pickAny;
  logic [NUM_REQ-1:0] winGnt;
  logic [IW-1:0]      winIdx;
  logic               winAny;
  logic [BUS_MAX-1:0] addrBus;
  logic [BUS_MAX-1:0] dataBus;
  logic [AW-1:0]      winAddr;
  logic [DW-1:0]      winData;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) uPick (
    .reqVec (Req),
    .ptr    (ptr),
    .gnt    (pickGnt),
    .idx    (pickIdx),
    .any    (pickAny)
  );

  assign nextPtr = (gIdx == LAST) ? '0 : gIdx + 1'b1;

`ifdef MEM_ARB_LOCK_EN
  logic locked;
  logic lockHit;

  // A held lock forces the previous owner if it still requests.
  assign lockHit = locked & Req[gIdx];
  assign winIdx  = lockHit ? gIdx : pickIdx;
  assign winGnt  = lockHit ? (NUM_REQ'(1) << gIdx) : pickGnt;
  assign winAny  = lockHit | pickAny;
`else
  assign winIdx = pickIdx;
  assign winGnt = pickGnt;
  assign winAny = pickAny;
`endif

  assign addrBus = BUS_MAX'(ReqAddr);
  assign dataBus = BUS_MAX'(ReqWData);
  assign winAddr = AW'(busSlice(addrBus, int'(winIdx), AW));
  assign winData = DW'(busSlice(dataBus, int'(winIdx), DW));

  // Transaction FSM with all memory and handshake outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      gIdx        <= '0;
      gWr         <= 1'b0;
      cnt         <= '0;
      Ack         <= '0;
      RData       <= '0;
      Grant       <= '0;
      Busy        <= 1'b0;
      Address     <= '0;
      WriteData   <= '0;
      WriteEnable <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
      locked      <= 1'b0;
`endif
    end else begin
      Ack <= '0;
      unique case (state)
        IDLE: begin
`ifdef MEM_ARB_LOCK_EN
          locked <= 1'b0;
`endif
          if (winAny) begin
            gIdx        <= winIdx;
            gWr         <= Wr[winIdx];
            Address     <= winAddr;
            WriteData   <= winData;
            WriteEnable <= Wr[winIdx];
            Grant       <= winGnt;
            Busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          WriteEnable <= 1'b0;
          if (gWr) begin
            Ack   <= Grant;
            state <= ACK;
          end else begin
            cnt   <= CNT_W'(READ_LAT);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(1)) begin
            RData <= ReadData;
            Ack   <= Grant;
            state <= ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK: begin
          Grant <= '0;
          Busy  <= 1'b0;
          state <= IDLE;
`ifdef MEM_ARB_LOCK_EN
          if (Lock[gIdx]) locked <= 1'b1;
          else            ptr    <= nextPtr;
`else
          ptr <= nextPtr;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random
// traffic checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int NR = 3;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int RL = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     Req = '0;
  logic [NR-1:0]     Wr = '0;
`ifdef MEM_ARB_LOCK_EN
  logic [NR-1:0]     Lock = '0;
`endif
  logic [NR*AW-1:0]  ReqAddr = '0;
  logic [NR*DW-1:0]  ReqWData = '0;
  logic [NR-1:0]     Ack;
  logic [DW-1:0]     RData;
  logic [NR-1:0]     Grant;
  logic              Busy;
  logic [AW-1:0]     Address;
  logic [DW-1:0]     WriteData;
  logic              WriteEnable;
  logic [DW-1:0]     ReadData;

  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NUM_REQ  (NR),
    .AW       (AW),
    .DW       (DW),
    .READ_LAT (RL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Req         (Req),
    .Wr          (Wr),
`ifdef MEM_ARB_LOCK_EN
    .Lock        (Lock),
`endif
    .ReqAddr     (ReqAddr),
    .ReqWData    (ReqWData),
    .Ack         (Ack),
    .RData       (RData),
    .Grant       (Grant),
    .Busy        (Busy),
    .Address     (Address),
    .WriteData   (WriteData),
    .WriteEnable (WriteEnable),
    .ReadData    (ReadData)
  );

  // Memory: write on strobe; read data appears RL cycles after ISSUE,
  // with noise on the pipe at every other time.
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] pipe [0:RL-1];
  logic [NR-1:0] prevGrant;

  assign ReadData = pipe[RL-1];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'(i);
    for (int i = 0; i < RL; i++) pipe[i] = '0;
    prevGrant = '0;
    forever begin
      @(posedge clk);
      if (WriteEnable) mem[Address[7:0]] <= WriteData;
      pipe[0] <= (Grant != 0 && prevGrant == 0) ?
                 mem[Address[7:0]] : DW'($urandom);
      for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
      prevGrant <= Grant;
    end
  end

  // Reference model: transactions, not states.
  typedef struct {
    logic [NR-1:0] ack;
    bit            isRd;
    logic [DW-1:0] rd;
    int            cyc;
  } exp_t;

  exp_t          expQ[$];
  logic [DW-1:0] refMem [0:255];
  int            cyc = 0;
  int            mPtr = 0;
  int            mFree = 0;
  int            mAckCyc = -1;
  int            mOwner = 0;
  bit            mLocked = 1'b0;

  initial begin : model
    int            w;
    exp_t          e;
    logic [AW-1:0] a;
    for (int i = 0; i < 256; i++) refMem[i] = DW'(i);
    forever begin
      @(posedge clk);
      if (rst_n) begin
        if (cyc == mAckCyc) begin
`ifdef MEM_ARB_LOCK_EN
          if (Lock[mOwner]) mLocked = 1'b1;
          else begin
            mLocked = 1'b0;
            mPtr = (mOwner + 1) % NR;
          end
`else
          mPtr = (mOwner + 1) % NR;
`endif
        end
        if (cyc >= mFree) begin
          w = -1;
          if (mLocked && Req[mOwner]) w = mOwner;
          else
            for (int k = 0; k < NR; k++)
              if (w < 0 && Req[(mPtr + k) % NR]) w = (mPtr + k) % NR;
          mLocked = 1'b0;
          if (w >= 0) begin
            a = ReqAddr[w*AW +: AW];
            e.ack = NR'(1) << w;
            if (Wr[w]) begin
              refMem[a[7:0]] = ReqWData[w*DW +: DW];
              e.isRd = 1'b0;
              e.rd = '0;
              e.cyc = cyc + 2;
            end else begin
              e.isRd = 1'b1;
              e.rd = refMem[a[7:0]];
              e.cyc = cyc + 2 + RL;
            end
            expQ.push_back(e);
            mOwner = w;
            mAckCyc = e.cyc;
            mFree = e.cyc + 1;
          end
        end
      end
      cyc = cyc + 1;
    end
  end

  initial begin
    forever begin
      @(negedge rst_n);
      expQ.delete();
      mPtr = 0;
      mFree = 0;
      mAckCyc = -1;
      mLocked = 1'b0;
    end
  end

  // Monitor: every Ack is matched against the model in order.
  logic [NR-1:0] ackLog[$];
  int            grantStarts = 0;

  initial begin : monitor
    exp_t          e;
    logic [NR-1:0] lastGrant;
    lastGrant = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        nCmp++;
        if ($countones(Grant) > 1) begin
          nErr++;
          $display("FAIL grant_onehot: Grant=%b at cycle %0d", Grant, cyc);
        end
        if (Grant != 0 && lastGrant == 0) grantStarts++;
        lastGrant = Grant;
        if (Ack != 0) begin
          ackLog.push_back(Ack);
          nCmp++;
          if (expQ.size() == 0) begin
            nErr++;
            $display("FAIL unexpected_ack: Ack=%b cycle %0d, none expected",
                     Ack, cyc);
          end else begin
            e = expQ.pop_front();
            if (Ack !== e.ack || cyc != e.cyc) begin
              nErr++;
              $display("FAIL ack_match: got Ack=%b @%0d, need %b @%0d",
                       Ack, cyc, e.ack, e.cyc);
            end
            if (e.isRd) begin
              nCmp++;
              if (RData !== e.rd) begin
                nErr++;
                $display("FAIL rdata: got %h, need %h", RData, e.rd);
              end
            end
          end
        end
      end else begin
        lastGrant = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(int i, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    Req[i] = 1'b1;
    Wr[i] = w;
    ReqAddr[i*AW +: AW] = a;
    ReqWData[i*DW +: DW] = d;
  endtask

  task automatic settle();
    Req = '0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    #2;
    nCmp++;
    if ({Ack, Grant, Busy, WriteEnable} !== '0) begin
      nErr++;
      $display("FAIL reset_ctrl: got %b, need 0", {Ack, Grant, Busy, WriteEnable});
    end
    nCmp++;
    if ({Address, WriteData, RData} !== '0) begin
      nErr++;
      $display("FAIL reset_data: got %h, need 0", {Address, WriteData, RData});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    nCmp++;
    if (Busy !== 1'b0 || Grant !== '0) begin
      nErr++;
      $display("FAIL reset_idle: Busy=%b Grant=%b, need 0", Busy, Grant);
    end
  endtask

  task automatic test_single_write();
    tick();
    setReq(0, 1'b1, 16'h0040, 16'h00A5);
    tick();
    @(negedge clk);
    nCmp++;
    if (WriteEnable !== 1'b1 || Address !== 16'h0040 ||
        WriteData !== 16'h00A5 || Grant !== 3'b001 || Busy !== 1'b1) begin
      nErr++;
      $display("FAIL wr_issue: WE=%b A=%h D=%h G=%b B=%b, need 1 0040 00a5 001 1",
               WriteEnable, Address, WriteData, Grant, Busy);
    end
    tick();
    @(negedge clk);
    nCmp++;
    if (Ack !== 3'b001 || WriteEnable !== 1'b0) begin
      nErr++;
      $display("FAIL wr_ack: Ack=%b WE=%b, need 001 0", Ack, WriteEnable);
    end
    tick();
    Req = '0;
    @(negedge clk);
    nCmp++;
    if (Ack !== '0 || Busy !== 1'b0 || Address !== 16'h0040) begin
      nErr++;
      $display("FAIL wr_after: Ack=%b B=%b A=%h, need 000 0 0040",
               Ack, Busy, Address);
    end
  endtask

  task automatic test_single_read();
    tick();
    setReq(1, 1'b0, 16'h0003, 16'h0000);
    for (int k = 1; k <= 2 + RL; k++) begin
      tick();
      @(negedge clk);
      nCmp++;
      if (k < 2 + RL) begin
        if (WriteEnable !== 1'b0 || Ack !== '0) begin
          nErr++;
          $display("FAIL rd_wait%0d: WE=%b Ack=%b, need 0 000", k, WriteEnable, Ack);
        end
      end else if (Ack !== 3'b010 || RData !== 16'h0003) begin
        nErr++;
        $display("FAIL rd_ack: Ack=%b RData=%h, need 010 0003", Ack, RData);
      end
    end
    tick();
    Req = '0;
  endtask

  task automatic test_contention();
    logic [NR-1:0] want [4];
    want = '{3'b001, 3'b010, 3'b001, 3'b010};
    settle();
    ackLog.delete();
    setReq(0, 1'b0, 16'h0010, 16'h0000);
    setReq(1, 1'b0, 16'h0021, 16'h0000);
    for (int k = 0; k < 80 && ackLog.size() < 4; k++) @(negedge clk);
    tick();
    Req = '0;
    nCmp++;
    if (ackLog.size() < 4) begin
      nErr++;
      $display("FAIL contention_timeout: acks %0d, need 4", ackLog.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        nCmp++;
        if (ackLog[k] !== want[k]) begin
          nErr++;
          $display("FAIL contention_order%0d: got %b, need %b", k, ackLog[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    settle();
    ackLog.delete();
    setReq(0, 1'b0, 16'h0007, 16'h0000);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    Req = '0;
    #1;
    nCmp++;
    if ({Ack, Grant, Busy, WriteEnable, Address, WriteData, RData} !== '0) begin
      nErr++;
      $display("FAIL midreset_outputs: Ack=%b G=%b B=%b WE=%b A=%h, need all 0",
               Ack, Grant, Busy, WriteEnable, Address);
    end
    repeat (6) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    nCmp++;
    if (ackLog.size() != 0) begin
      nErr++;
      $display("FAIL midreset_noack: got %0d acks, need 0", ackLog.size());
    end
    setReq(0, 1'b0, 16'h0007, 16'h0000);
    for (int k = 0; k < 20 && ackLog.size() < 1; k++) @(negedge clk);
    tick();
    Req = '0;
    nCmp++;
    if (ackLog.size() != 1 || ackLog[0] !== 3'b001) begin
      nErr++;
      $display("FAIL midreset_resume: acks %0d first %b, need 1 001",
               ackLog.size(), ackLog.size() > 0 ? ackLog[0] : '0);
    end
  endtask

  task automatic test_dropped();
    int g0;
    settle();
    ackLog.delete();
    g0 = grantStarts;
    setReq(0, 1'b1, 16'h0050, 16'h1234);
    tick();
    Req = '0;
    repeat (10) tick();
    nCmp++;
    if (ackLog.size() != 1 || ackLog[0] !== 3'b001) begin
      nErr++;
      $display("FAIL dropped_ack: acks %0d, need exactly one 001", ackLog.size());
    end
    nCmp++;
    if (grantStarts - g0 != 1) begin
      nErr++;
      $display("FAIL dropped_grants: got %0d grants, need 1", grantStarts - g0);
    end
  endtask

`ifdef MEM_ARB_LOCK_EN
  task automatic test_lock();
    logic [NR-1:0] want [3];
    want = '{3'b001, 3'b001, 3'b010};
    settle();
    ackLog.delete();
    setReq(2, 1'b1, 16'h0060, 16'h0ABC);
    for (int k = 0; k < 20 && ackLog.size() < 1; k++) @(negedge clk);
    tick();
    Req = '0;
    settle();
    ackLog.delete();
    Lock = 3'b001;
    setReq(0, 1'b0, 16'h0010, 16'h0000);
    setReq(1, 1'b0, 16'h0021, 16'h0000);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (ackLog.size() >= 3) break;
      tick();
      if (ackLog.size() >= 1) Lock = '0;
    end
    tick();
    Req = '0;
    Lock = '0;
    nCmp++;
    if (ackLog.size() < 3) begin
      nErr++;
      $display("FAIL lock_timeout: acks %0d, need 3", ackLog.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        nCmp++;
        if (ackLog[k] !== want[k]) begin
          nErr++;
          $display("FAIL lock_order%0d: got %b, need %b", k, ackLog[k], want[k]);
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [NR-1:0] seen;
    settle();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      seen = Ack;
      tick();
      for (int i = 0; i < NR; i++) begin
        if (seen[i]) Req[i] = 1'b0;
        else if (!Req[i] && $urandom_range(99) < 30)
          setReq(i, 1'($urandom_range(1)), {8'h00, 8'($urandom)}, 16'($urandom));
        else if ($urandom_range(99) < 10)
          ReqWData[i*DW +: DW] = 16'($urandom);
      end
    end
    Req = '0;
    for (int k = 0; k < 100 && expQ.size() != 0; k++) @(negedge clk);
    nCmp++;
    if (expQ.size() != 0) begin
      nErr++;
      $display("FAIL random_drain: %0d transactions outstanding, need 0", expQ.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_reset_mid_read();
    test_dropped();
`ifdef MEM_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
